// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the MIPS pipeline datapath and pipe_hazard_ctrl.
// The datapath is the master: it drives the decode/execute status fields and receives the stall/flush controls.
interface pipe_hazard_if;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_uses_rt;
  logic       i_id_reads_hilo;
  logic       i_id_md_start;
  logic       i_ex_memread;
  logic [4:0] i_ex_rd;
  logic       i_ex_branch_taken;
  logic       i_exception;
  logic       o_pc_we;
  logic       o_fd_we;
  logic       o_fd_flush;
  logic       o_de_flush;
  logic       o_exc_redirect;
  logic [1:0] o_state;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_id_reads_hilo, i_id_md_start,
           i_ex_memread, i_ex_rd, i_ex_branch_taken, i_exception,
    input  o_pc_we, o_fd_we, o_fd_flush, o_de_flush, o_exc_redirect, o_state
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_reads_hilo, i_id_md_start,
           i_ex_memread, i_ex_rd, i_ex_branch_taken, i_exception,
    output o_pc_we, o_fd_we, o_fd_flush, o_de_flush, o_exc_redirect, o_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: PC / IF-ID / ID-EX write enables and flushes
// for load-use, HI/LO latency, taken branches and the multi-cycle exception flush.
module pipe_hazard_ctrl #(
  parameter int MD_LAT  = 4,
  parameter int EXC_CYC = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  pipe_hazard_if.slave hz
);

  localparam int EXC_W = (EXC_CYC > 1) ? $clog2(EXC_CYC) : 1;
  localparam logic [EXC_W-1:0] EXC_LOAD = EXC_W'(EXC_CYC - 1);
  // md_cnt holds the number of cycles a HI/LO consumer must still wait, so the
  // issue cycle itself consumes one of the MD_LAT cycles.
  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_EXC = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [EXC_W-1:0] exc_cnt_q, exc_cnt_d;

  logic lu, md_stall;
  logic pc_we, fd_we, fd_flush, de_flush, exc_redirect;

  assign lu = hz.i_ex_memread && (hz.i_ex_rd != 5'd0) &&
              ((hz.i_ex_rd == hz.i_id_rs) || (hz.i_id_uses_rt && (hz.i_ex_rd == hz.i_id_rt)));
  assign md_stall = (md_cnt_q != 4'd0) && (hz.i_id_reads_hilo || hz.i_id_md_start);

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = (md_cnt_q != 4'd0) ? md_cnt_q - 4'd1 : 4'd0;
    exc_cnt_d    = exc_cnt_q;
    pc_we        = 1'b1;
    fd_we        = 1'b1;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    exc_redirect = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (hz.i_exception) begin
          state_d   = ST_EXC;
          exc_cnt_d = EXC_LOAD;
          md_cnt_d  = 4'd0;
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
        end else if (hz.i_ex_branch_taken) begin
          // Decode is squashed, so its hazards are moot and a mul/div there never issues.
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (lu || md_stall) begin
          pc_we    = 1'b0;
          fd_we    = 1'b0;
          de_flush = 1'b1;
        end else if (hz.i_id_md_start) begin
          md_cnt_d = MD_LOAD;
        end
      end
      ST_EXC: begin
        fd_we    = 1'b0;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (hz.i_exception) begin
          exc_cnt_d = EXC_LOAD;
          pc_we     = 1'b0;
        end else if (exc_cnt_q != '0) begin
          exc_cnt_d = exc_cnt_q - 1'b1;
          pc_we     = 1'b0;
        end else begin
          exc_redirect = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= 4'd0;
      exc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      exc_cnt_q <= exc_cnt_d;
    end
  end

  // Reset gates the outputs directly so an asserted reset aborts a sequence without waiting for a clock.
  assign hz.o_pc_we        = i_rst_n & pc_we;
  assign hz.o_fd_we        = i_rst_n & fd_we;
  assign hz.o_fd_flush     = ~i_rst_n | fd_flush;
  assign hz.o_de_flush     = ~i_rst_n | de_flush;
  assign hz.o_exc_redirect = i_rst_n & exc_redirect;
  assign hz.o_state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=4, EXC_CYC=2): each task drives one scenario
// and compares the packed output word {pc_we, fd_we, fd_flush, de_flush, exc_redirect, state}.
module tb_pipe_hazard_ctrl;

  // Expected output words, hand-derived from the sequencer behaviour.
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_RST   = 7'b0011000;
  localparam logic [6:0] O_ENTRY = 7'b0011000;
  localparam logic [6:0] O_EXC   = 7'b0011001;
  localparam logic [6:0] O_RDR   = 7'b1011101;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MD_LAT(4), .EXC_CYC(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {hz.o_pc_we, hz.o_fd_we, hz.o_fd_flush, hz.o_de_flush, hz.o_exc_redirect, hz.o_state};
  endfunction

  task automatic clear_inputs();
    hz.i_id_rs           = 5'd0;
    hz.i_id_rt           = 5'd0;
    hz.i_id_uses_rt      = 1'b0;
    hz.i_id_reads_hilo   = 1'b0;
    hz.i_id_md_start     = 1'b0;
    hz.i_ex_memread      = 1'b0;
    hz.i_ex_rd           = 5'd0;
    hz.i_ex_branch_taken = 1'b0;
    hz.i_exception       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs() !== O_RST) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", obs(), O_RST);
    end
    hz.i_ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (obs() !== O_RST) begin
      errors++;
      $display("FAIL reset_branch_gated: got %b want %b", obs(), O_RST);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== O_RUN) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs(), O_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_seq [6];
    exp_seq = '{O_STALL, O_RUN, O_RUN, O_RUN, O_STALL, O_RUN};
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      case (c)
        0: begin hz.i_ex_memread = 1'b1; hz.i_ex_rd = 5'd5; hz.i_id_rs = 5'd5; end
        2: begin hz.i_ex_memread = 1'b1; hz.i_ex_rd = 5'd0; hz.i_id_rs = 5'd0; end
        3: begin hz.i_ex_memread = 1'b1; hz.i_ex_rd = 5'd5; hz.i_id_rs = 5'd3; hz.i_id_rt = 5'd5; end
        4: begin hz.i_ex_memread = 1'b1; hz.i_ex_rd = 5'd5; hz.i_id_rs = 5'd3; hz.i_id_rt = 5'd5;
                 hz.i_id_uses_rt = 1'b1; end
        default: ;
      endcase
      #1;
      checks++;
      if (obs() !== exp_seq[c]) begin
        errors++;
        $display("FAIL load_use cycle %0d: got %b want %b", c, obs(), exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_mul_div();
    logic [6:0] exp_seq [14];
    // Issue, 3 HI/LO stalls, advance; then back-to-back issue and drain.
    exp_seq = '{O_RUN, O_STALL, O_STALL, O_STALL, O_RUN,
                O_RUN, O_STALL, O_STALL, O_STALL, O_RUN,
                O_STALL, O_STALL, O_STALL, O_RUN};
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      hz.i_id_md_start   = (c == 0) || (c == 5) || (c == 6) || (c == 7) || (c == 8) || (c == 9);
      hz.i_id_reads_hilo = (c >= 1 && c <= 4) || (c >= 10);
      #1;
      checks++;
      if (obs() !== exp_seq[c]) begin
        errors++;
        $display("FAIL mul_div cycle %0d: got %b want %b", c, obs(), exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [6:0] exp_seq [3];
    exp_seq = '{O_BR, O_RUN, O_BR};
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      case (c)
        0: begin hz.i_ex_branch_taken = 1'b1; hz.i_ex_memread = 1'b1; hz.i_ex_rd = 5'd7;
                 hz.i_id_rs = 5'd7; hz.i_id_md_start = 1'b1; end
        1: hz.i_id_reads_hilo = 1'b1;
        2: hz.i_ex_branch_taken = 1'b1;
        default: ;
      endcase
      #1;
      checks++;
      if (obs() !== exp_seq[c]) begin
        errors++;
        $display("FAIL branch cycle %0d: got %b want %b", c, obs(), exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_exception();
    logic [6:0] exp_seq [9];
    // Single pulse (branch/lu held during EXC are ignored), then a re-pulse in cycle 1.
    exp_seq = '{O_ENTRY, O_EXC, O_RDR, O_RUN,
                O_ENTRY, O_EXC, O_EXC, O_RDR, O_RUN};
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      hz.i_exception = (c == 0) || (c == 4) || (c == 5);
      if (c == 1 || c == 2) begin
        hz.i_ex_branch_taken = 1'b1;
        hz.i_ex_memread = 1'b1;
        hz.i_ex_rd = 5'd9;
        hz.i_id_rs = 5'd9;
      end
      #1;
      checks++;
      if (obs() !== exp_seq[c]) begin
        errors++;
        $display("FAIL exception cycle %0d: got %b want %b", c, obs(), exp_seq[c]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 2; s++) begin
      clear_inputs();
      if (s == 0) hz.i_exception = 1'b1;
      else hz.i_id_md_start = 1'b1;
      tick();
      clear_inputs();
      hz.i_id_reads_hilo = (s == 1);
      #1;
      checks++;
      if (obs() !== ((s == 0) ? O_EXC : O_STALL)) begin
        errors++;
        $display("FAIL reset_mid_pre s%0d: got %b want %b", s, obs(), (s == 0) ? O_EXC : O_STALL);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== O_RST) begin
        errors++;
        $display("FAIL reset_mid_async s%0d: got %b want %b", s, obs(), O_RST);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      hz.i_id_reads_hilo = 1'b1;
      #1;
      checks++;
      if (obs() !== O_RUN) begin
        errors++;
        $display("FAIL reset_mid_release s%0d: got %b want %b", s, obs(), O_RUN);
      end
      tick();
      checks++;
      if (obs() !== O_RUN) begin
        errors++;
        $display("FAIL reset_mid_mfhi s%0d: got %b want %b", s, obs(), O_RUN);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mul_div();
    test_branch();
    test_exception();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
